// File: rtl/reg_file.sv
`default_nettype none
// =============================================================================
// Module      : reg_file
// Description : 32 x XLEN RV32I register file, two combinational read ports,
//               one synchronous write port, x0 hardwired to zero.
// Revision    : 1.0 - initial release
// =============================================================================
module reg_file #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] write_data,
  input  logic            reg_write,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2
);

  // x0 has no storage; entries 1..NREGS-1 only.
  logic [XLEN-1:0] r_regs [1:NREGS-1];

  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (reg_write && (rd != '0)) begin
      r_regs[rd] <= write_data;
    end
  end

  function automatic logic [XLEN-1:0] f_read(
    input logic [AW-1:0]   a,
    input logic [XLEN-1:0] stored,
    input logic            rst_n,
    input logic            we,
    input logic [AW-1:0]   wa,
    input logic [XLEN-1:0] wd
  );
    logic [XLEN-1:0] v;
    v = '0;
    // Gating with reset keeps a pending bypass from leaking out while held in reset.
    if (rst_n && (a != '0)) begin
      v = stored;
      if (BYPASS && we && (wa == a)) begin
        v = wd;
      end
    end
    return v;
  endfunction

  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (rs1 != '0) begin
      w_rd1 = f_read(rs1, r_regs[rs1], reset, reg_write, rd, write_data);
    end
    if (rs2 != '0) begin
      w_rd2 = f_read(rs2, r_regs[rs2], reset, reg_write, rd, write_data);
    end
  end

  assign read_data1 = w_rd1;
  assign read_data2 = w_rd2;

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// =============================================================================
// Module      : tb_reg_file
// Description : Self-checking bench for reg_file against an array model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] read_data1, read_data2;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [32];

  always #5 clk = ~clk;

  reg_file #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .write_data (write_data),
    .reg_write  (reg_write),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (!reset || a == 5'd0) return 32'h0;
    if (reg_write && rd == a) return write_data;
    return model[a];
  endfunction

  task automatic clear_model();
    foreach (model[i]) model[i] = 32'h0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic en);
    @(negedge clk);
    rd = a; write_data = d; reg_write = en;
    @(posedge clk);
    if (en && a != 5'd0) model[a] = d;
    #1;
    reg_write = 1'b0;
  endtask

  task automatic rd_pair(input logic [4:0] a1, input logic [4:0] a2);
    rs1 = a1; rs2 = a2;
    #2;
  endtask

  initial begin
    reset = 1'b0; reg_write = 1'b0; rd = '0; write_data = '0; rs1 = '0; rs2 = '0;
    clear_model();
    #12 reset = 1'b1;
    rd_pair(5'd5, 5'd31);
    chk("por_rs1", read_data1, 32'h0);
    chk("por_rs2", read_data2, 32'h0);

    // Give registers non-zero contents, then a 5 ns reset pulse
    do_write(5'd5, 32'h0000_0001, 1'b1);
    do_write(5'd31, 32'h0000_0002, 1'b1);
    @(negedge clk); #2;
    reset = 1'b0; #5; reset = 1'b1;
    clear_model();
    rd_pair(5'd5, 5'd31);
    chk("rst_rs1", read_data1, 32'h0);
    chk("rst_rs2", read_data2, 32'h0);

    do_write(5'd5,  32'hAAAA_5555, 1'b1);
    do_write(5'd10, 32'h1234_5678, 1'b1);
    do_write(5'd15, 32'hDEAD_BEEF, 1'b1);
    rd_pair(5'd5, 5'd10);
    chk("basic_x5",  read_data1, 32'hAAAA_5555);
    chk("basic_x10", read_data2, 32'h1234_5678);
    rd_pair(5'd15, 5'd0);
    chk("basic_x15", read_data1, 32'hDEAD_BEEF);
    chk("basic_x0",  read_data2, 32'h0);

    do_write(5'd5, 32'h1111_2222, 1'b1);
    rd_pair(5'd5, 5'd10);
    chk("ovw_x5",  read_data1, 32'h1111_2222);
    chk("ovw_x10", read_data2, 32'h1234_5678);
    rd_pair(5'd15, 5'd15);
    chk("ovw_x15", read_data1, 32'hDEAD_BEEF);
    chk("same_reg_both", read_data2, 32'hDEAD_BEEF);

    do_write(5'd0, 32'hFFFF_FFFF, 1'b1);
    rd_pair(5'd0, 5'd0);
    chk("x0_write", read_data1, 32'h0);
    do_write(5'd10, 32'hCAFE_BABE, 1'b0);
    rd_pair(5'd10, 5'd0);
    chk("we_off_x10", read_data1, 32'h1234_5678);

    // Read-during-write forwarding
    @(negedge clk);
    rs1 = 5'd7; rs2 = 5'd7; rd = 5'd7; write_data = 32'h0BAD_F00D; reg_write = 1'b1;
    #1;
    chk("byp_pre_rs1", read_data1, 32'h0BAD_F00D);
    chk("byp_pre_rs2", read_data2, 32'h0BAD_F00D);
    @(posedge clk);
    model[7] = 32'h0BAD_F00D;
    #1 reg_write = 1'b0;
    #1;
    chk("byp_post_rs1", read_data1, 32'h0BAD_F00D);
    chk("byp_post_rs2", read_data2, 32'h0BAD_F00D);

    // rd = 0 with a matching read address must not be forwarded
    @(negedge clk);
    rs1 = 5'd0; rd = 5'd0; write_data = 32'h5A5A_5A5A; reg_write = 1'b1;
    #1;
    chk("byp_x0", read_data1, 32'h0);
    reg_write = 1'b0;

    // Async reset between edges, held across an edge with a pending write
    @(negedge clk); #1;
    rs1 = 5'd5; rs2 = 5'd10;
    reset = 1'b0;
    #1;
    chk("async_x5",  read_data1, 32'h0);
    chk("async_x10", read_data2, 32'h0);
    rs1 = 5'd15; rd = 5'd15; write_data = 32'h7777_7777; reg_write = 1'b1; rs2 = 5'd15;
    #1;
    chk("async_x15", read_data1, 32'h0);
    chk("async_nobyp", read_data2, 32'h0);
    @(posedge clk); #1;
    reg_write = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    clear_model();
    #1;
    chk("rst_write_ignored", read_data1, 32'h0);

    // Randomized traffic against the array model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rs1        = 5'($urandom_range(0, 31));
      rs2        = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom_range(0, 31));
      rd         = ($urandom_range(0, 2) == 0) ? rs1 : 5'($urandom_range(0, 31));
      write_data = $urandom;
      reg_write  = 1'($urandom_range(0, 1));
      #2;
      chk("rand_rs1", read_data1, ref_read(rs1));
      chk("rand_rs2", read_data2, ref_read(rs2));
      if ($urandom_range(0, 24) == 0) begin
        reset = 1'b0;
        #1;
        chk("rand_rst_rs1", read_data1, 32'h0);
        chk("rand_rst_rs2", read_data2, 32'h0);
        clear_model();
        reset = 1'b1;
        #1;
        chk("rand_after_rst", read_data1, ref_read(rs1));
      end
      @(posedge clk);
      if (reg_write && rd != 5'd0) model[rd] = write_data;
    end

    @(negedge clk);
    reg_write = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rs1 = 5'(a); rs2 = 5'(31 - a);
      #1;
      chk("sweep_rs1", read_data1, ref_read(rs1));
      chk("sweep_rs2", read_data2, ref_read(rs2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry x 32-bit general-purpose register file for the RV32I datapath core.
- Two combinational read ports (rs1, rs2) and one synchronous write port (rd).
- Register x0 is hardwired to zero.
- Sits between the decode stage (register addresses) and the execute/writeback stages (operands and result).

Parameters:
- XLEN, 32, data width of each register and of the data ports.
- NREGS, 32, number of architectural registers; address width is log2(NREGS) = 5.
- BYPASS, 1, when 1 a same-cycle write to a register being read is forwarded to the read port; when 0 the read returns the stored (old) value.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all registers.
- rs1  input  5  read address, port 1.
- rs2  input  5  read address, port 2.
- rd  input  5  write address.
- write_data  input  XLEN  data to write to register rd.
- reg_write  input  1  write enable, active-high, sampled on the rising edge of clk.
- read_data1  output  XLEN  contents of register rs1.
- read_data2  output  XLEN  contents of register rs2.

Behaviour:
- Storage: registers x1..x31, XLEN bits each. x0 has no storage.
- Reset (reset = 0):
  - Asynchronously clears x1..x31 to 32'h00000000, independent of clk.
  - Held in reset: all writes are ignored and both read ports return 0.
  - Deassertion (0 -> 1) takes effect immediately; the first write can occur on the next rising clk edge with reset = 1.
  - Reset asserted mid-write (same cycle as reg_write = 1) wins: the register is cleared.
- Write:
  - On the rising edge of clk with reset = 1 and reg_write = 1, register rd is loaded with write_data.
  - rd = 0: the write is discarded and x0 stays 0.
  - reg_write = 0: no register changes.
  - Write latency is one edge; the new value is visible on the read ports after that edge.
- Read:
  - Purely combinational, zero cycle latency. read_data1 = x[rs1], read_data2 = x[rs2].
  - Outputs follow address changes within the same cycle, with no clock needed.
  - rs1 = 0 or rs2 = 0 always returns 0.
  - Both ports may read the same register simultaneously and both return the same value.
- Read-during-write (reg_write = 1, rd != 0, rd == rsN, reset = 1, before the edge):
  - BYPASS = 1: read_dataN shows write_data combinationally.
  - BYPASS = 0: read_dataN shows the old stored value until the edge.
  - rd = 0 is never forwarded.
- Overwrite: a later write to the same rd fully replaces the prior value. No other register is disturbed.
- Inputs are only sampled at the edge. Changes to rd, write_data or reg_write between edges do not alter state.
- No X propagation: all registers are defined after reset. Reads of never-written registers return 0 after reset.

Test Plan:
- Reset: assert reset = 0 for 5 ns with arbitrary prior contents, release -> reading any pair (e.g. rs1 = 5, rs2 = 31) gives 00000000/00000000.
- Basic writes and reads:
  - Write x5 = AAAA5555, x10 = 12345678, x15 = DEADBEEF, one clk edge each with reg_write = 1.
  - Set rs1 = 5, rs2 = 10 -> read_data1 = AAAA5555, read_data2 = 12345678 within 2 ns, no clock needed.
  - Set rs1 = 15, rs2 = 0 -> DEADBEEF / 00000000.
- Overwrite: write x5 = 11112222, then read rs1 = 5, rs2 = 10 -> 11112222 / 12345678; x15 is still DEADBEEF.
- x0 and write enable:
  - Write rd = 0 with FFFFFFFF -> read rs1 = 0 gives 00000000.
  - Drive rd = 10, write_data = CAFEBABE with reg_write = 0 across an edge -> x10 is still 12345678.
- Read-during-write (BYPASS = 1): rs1 = rs2 = 7, rd = 7, write_data = 0BADF00D, reg_write = 1 before the edge -> both outputs show 0BADF00D immediately and keep it after the edge.
- Async reset mid-operation: after the writes above, pulse reset low between clock edges -> x5, x10 and x15 read 0 immediately, without waiting for a clock edge.
